// File: rtl/w5300_bus_master.sv
// w5300_bus_master: timed W5300 parallel-bus master with burst access and irq sync
module w5300_bus_master #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 8,
  parameter int T_SETUP   = 1,
  parameter int T_STROBE  = 4,
  parameter int T_HOLD    = 1,
  parameter int T_RECOVER = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              wdata_next,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic              irq,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic [ADDR_W-1:0] addr,
  output logic              cs_n,
  output logic              rd_n,
  output logic              we_n,
  output logic              rw_n,
  input  logic              int_n
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;
  localparam int TM0  = T_SETUP > T_STROBE ? T_SETUP : T_STROBE;
  localparam int TM1  = T_HOLD > T_RECOVER ? T_HOLD : T_RECOVER;
  localparam int TMAX = TM0 > TM1 ? TM0 : TM1;
  localparam int CW   = $clog2(TMAX + 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [LEN_W-1:0] rem;
  logic [DATA_W-1:0] wdata_q;
  logic wr_q;
  logic [1:0] sync;
  logic accept, last_strobe, wr, act_d;
  assign accept      = req_valid && req_ready;
  assign last_strobe = state == STROBE && cnt == '0;
  assign wr          = accept ? req_write : wr_q;
  assign act_d       = state_d == SETUP || state_d == STROBE || state_d == HOLD;
  // next state; the phase counter reloads with the new phase length on every state entry
  always_comb begin
    state_d = state;
    cnt_d   = cnt - 1'b1;
    case (state)
      IDLE: begin
        cnt_d = cnt;
        if (accept) begin
          state_d = SETUP;
          cnt_d   = CW'(T_SETUP - 1);
        end
      end
      SETUP:   if (cnt == '0) begin state_d = STROBE;  cnt_d = CW'(T_STROBE - 1);  end
      STROBE:  if (cnt == '0) begin state_d = HOLD;    cnt_d = CW'(T_HOLD - 1);    end
      HOLD:    if (cnt == '0) begin state_d = RECOVER; cnt_d = CW'(T_RECOVER - 1); end
      RECOVER: if (cnt == '0) begin state_d = rem != '0 ? SETUP : IDLE; cnt_d = CW'(T_SETUP - 1); end
      default: state_d = IDLE;
    endcase
  end
  // state, phase counter and per-request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        wr_q <= req_write;
        rem  <= req_len;
      end else if (state == RECOVER && cnt == '0 && rem != '0) begin
        rem <= rem - 1'b1;
      end
      if (wdata_next) wdata_q <= req_wdata;
    end
  end
  // registered pin and response outputs decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      we_n       <= 1'b1;
      rw_n       <= 1'b1;
      data_oe    <= 1'b0;
      addr       <= '0;
      data_out   <= '0;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      rsp_rdata  <= '0;
      wdata_next <= 1'b0;
    end else begin
      req_ready  <= state_d == IDLE;
      busy       <= state_d != IDLE;
      cs_n       <= !act_d;
      rd_n       <= !(state_d == STROBE && !wr);
      we_n       <= !(state_d == STROBE && wr);
      rw_n       <= !(act_d && wr);
      data_oe    <= act_d && wr;
      rsp_valid  <= last_strobe;
      rsp_last   <= last_strobe && rem == '0;
      wdata_next <= last_strobe && wr_q && rem != '0;
      if (accept) addr <= req_addr;
      if (state_d == SETUP && state != SETUP && wr) data_out <= accept ? req_wdata : wdata_q;
      if (last_strobe && !wr_q) rsp_rdata <= data_in;
    end
  end
  // two-flop synchroniser on the asynchronous interrupt, then registered inversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      irq  <= 1'b0;
    end else begin
      sync <= {sync[0], int_n};
      irq  <= !sync[1];
    end
  end
endmodule

// File: tb/tb_w5300_bus_master.sv
// tb_w5300_bus_master: vector-table and directed checks for w5300_bus_master
module tb_w5300_bus_master;
  typedef struct packed {
    logic req_ready, wdata_next, rsp_valid, rsp_last, busy, irq, data_oe, cs_n, rd_n, we_n, rw_n;
    logic [15:0] rsp_rdata;
    logic [15:0] data_out;
    logic [9:0]  addr;
  } out_t;
  typedef struct {
    bit sel;
    bit write;
    logic [9:0] addr;
    logic [15:0] wdata;
    logic [7:0] len;
    logic [15:0] din;
    int per, cs, rd, we, oe, rsp, first, rdy;
  } vec_t;
  logic clk = 0, rst = 1, req_valid = 0, req_write = 0, int_n = 1, sel = 0;
  logic [9:0] req_addr = '0;
  logic [15:0] req_wdata = '0, data_in = '0;
  logic [7:0] req_len = '0;
  logic rr0, wn0, rv0, rl0, bz0, iq0, oe0, cs0, rd0, we0, rw0;
  logic rr1, wn1, rv1, rl1, bz1, iq1, oe1, cs1, rd1, we1, rw1;
  logic [15:0] rdat0, dout0, rdat1, dout1;
  logic [9:0] ad0, ad1;
  out_t o0, o1, o;
  int pass_cnt = 0, total = 0;
  vec_t vecs[7];
  assign o0 = {rr0, wn0, rv0, rl0, bz0, iq0, oe0, cs0, rd0, we0, rw0, rdat0, dout0, ad0};
  assign o1 = {rr1, wn1, rv1, rl1, bz1, iq1, oe1, cs1, rd1, we1, rw1, rdat1, dout1, ad1};
  assign o  = sel ? o1 : o0;
  always #5 clk = ~clk;
  w5300_bus_master u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .wdata_next(wn0),
    .rsp_valid(rv0), .rsp_rdata(rdat0), .rsp_last(rl0), .busy(bz0), .irq(iq0),
    .data_in(data_in), .data_out(dout0), .data_oe(oe0), .addr(ad0),
    .cs_n(cs0), .rd_n(rd0), .we_n(we0), .rw_n(rw0), .int_n(int_n)
  );
  w5300_bus_master #(.T_STROBE(1), .T_RECOVER(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .wdata_next(wn1),
    .rsp_valid(rv1), .rsp_rdata(rdat1), .rsp_last(rl1), .busy(bz1), .irq(iq1),
    .data_in(data_in), .data_out(dout1), .data_oe(oe1), .addr(ad1),
    .cs_n(cs1), .rd_n(rd1), .we_n(we1), .rw_n(rw1), .int_n(int_n)
  );
  task automatic chk(input string n, input longint a, input longint e);
    total++;
    if (a == e) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
  endtask
  task automatic start_req();
    int c = 0;
    while (!(rr0 && rr1) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("idle_wait", rr0 && rr1, 1);
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  task automatic run(input int i, input vec_t v);
    int cs = 0, rd = 0, we = 0, oe = 0, nr = 0, first = 0, rdy = 0;
    int bad_d = 0, bad_p = 0, bad_s = 0, bad_l = 0;
    sel = v.sel; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    req_len = v.len; data_in = v.din;
    start_req();
    for (int c = 1; c <= 3000 && rdy == 0; c++) begin
      @(negedge clk);
      if (!o.cs_n) begin
        cs++;
        if (o.addr != v.addr) bad_p++;
      end
      if (!o.rd_n) rd++;
      if (!o.we_n) we++;
      if (o.data_oe) oe++;
      if (o.data_oe && !o.rd_n) bad_p++;
      if (o.rw_n != !(v.write && !o.cs_n)) bad_p++;
      if (o.busy == o.req_ready) bad_p++;
      if (o.data_oe && o.data_out != 16'(v.wdata + nr)) bad_d++;
      if (o.rsp_valid) begin
        if (nr == 0) first = c;
        else if (c != first + nr * v.per) bad_s++;
        if (!v.write && o.rsp_rdata != 16'(v.din + nr)) bad_d++;
        if (o.rsp_last != (nr == int'(v.len))) bad_l++;
        nr++;
      end else if (o.rsp_last) bad_l++;
      if (o.wdata_next) begin
        if (!v.write) bad_p++;
        req_wdata = 16'(v.wdata + nr);
      end
      data_in = 16'(v.din + nr);
      if (o.req_ready) rdy = c;
    end
    chk($sformatf("v%0d_cs_low", i), cs, v.cs);
    chk($sformatf("v%0d_rd_low", i), rd, v.rd);
    chk($sformatf("v%0d_we_low", i), we, v.we);
    chk($sformatf("v%0d_oe_high", i), oe, v.oe);
    chk($sformatf("v%0d_rsp_count", i), nr, v.rsp);
    chk($sformatf("v%0d_first_rsp", i), first, v.first);
    chk($sformatf("v%0d_ready_cycle", i), rdy, v.rdy);
    chk($sformatf("v%0d_data_errs", i), bad_d, 0);
    chk($sformatf("v%0d_proto_errs", i), bad_p, 0);
    chk($sformatf("v%0d_spacing_errs", i), bad_s, 0);
    chk($sformatf("v%0d_last_errs", i), bad_l, 0);
  endtask
  initial begin
    int lat, seen;
    vecs[0] = '{0, 0, 10'h200, 16'h0000, 8'd0,   16'hA55A, 8, 6,    4,    0, 0,  1,   6, 9};
    vecs[1] = '{0, 1, 10'h004, 16'h1234, 8'd0,   16'h0000, 8, 6,    0,    4, 6,  1,   6, 9};
    vecs[2] = '{0, 0, 10'h22E, 16'h0000, 8'd3,   16'h0001, 8, 24,   16,   0, 0,  4,   6, 33};
    vecs[3] = '{0, 1, 10'h155, 16'hBEEF, 8'd1,   16'h0000, 8, 12,   0,    8, 12, 2,   6, 17};
    vecs[4] = '{0, 0, 10'h3FF, 16'h0000, 8'd255, 16'hFF00, 8, 1536, 1024, 0, 0,  256, 6, 2049};
    vecs[5] = '{1, 0, 10'h0AA, 16'h0000, 8'd1,   16'h0BAD, 4, 6,    2,    0, 0,  2,   3, 9};
    vecs[6] = '{1, 1, 10'h2AA, 16'h5A5A, 8'd0,   16'h0000, 4, 3,    0,    1, 3,  1,   3, 5};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {o0.cs_n, o0.rd_n, o0.we_n, o0.rw_n}, 4'hF);
    chk("rst_ready", o0.req_ready, 0);
    chk("rst_flags", {o0.data_oe, o0.rsp_valid, o0.rsp_last, o0.wdata_next, o0.busy, o0.irq}, 0);
    chk("rst_buses", {o0.addr, o0.data_out, o0.rsp_rdata}, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", o0.req_ready, 1);
    foreach (vecs[i]) run(i, vecs[i]);
    sel = 0; req_write = 0; req_addr = 10'h123; req_len = 0; data_in = 16'h7777;
    start_req();
    repeat (3) @(negedge clk);
    chk("pre_abort_rd_low", o0.rd_n, 0);
    rst = 1;
    #1;
    chk("abort_cs_n", o0.cs_n, 1);
    chk("abort_rd_n", o0.rd_n, 1);
    chk("abort_ready", o0.req_ready, 0);
    seen = int'(o0.rsp_valid);
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1 chk("abort_ready_back", o0.req_ready, 1);
    repeat (8) begin
      @(negedge clk);
      seen += int'(o0.rsp_valid || !o0.cs_n);
    end
    chk("abort_no_rsp", seen, 0);
    int_n = 0;
    lat = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (o0.irq && lat == 0) lat = c;
    end
    chk("irq_rise_latency", lat, 3);
    int_n = 1;
    lat = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (!o0.irq && lat == 0) lat = c;
    end
    chk("irq_fall_latency", lat, 3);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/w5300_bus_master.md
Name: w5300_bus_master

Overview:
- Parametrised W5300 parallel-bus master.
- Turns a valid/ready register-access request stream into timed cs_n/rd_n/we_n/addr/data cycles.
- Adds programmable timing, configurable data/address width, repeated-address burst access (for the Sn_TX/RX FIFO registers) and interrupt synchronisation.
- Sits between the socket/command logic and the W5300 pins. The board top owns the tri-state buffer on data.

Parameters:
- ADDR_W, 10, W5300 address width.
- DATA_W, 16, bus data width; legal values are 8 or 16.
- LEN_W, 8, burst length field width.
- T_SETUP, 1, cycles with cs_n low before strobe; must be ≥1.
- T_STROBE, 4, cycles rd_n/we_n held low; must be ≥1.
- T_HOLD, 1, cycles after strobe release with cs_n still low; must be ≥1.
- T_RECOVER, 2, cycles cs_n held high between accesses; must be ≥1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  register address.
- req_wdata  in  DATA_W  write data; sampled per word (see Behaviour).
- req_len  in  LEN_W  burst length; N means N+1 accesses.
- wdata_next  out  1  one-cycle pulse requesting the next req_wdata word during a write burst.
- rsp_valid  out  1  one-cycle pulse per completed word.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads.
- rsp_last  out  1  marks the final word of a burst, with rsp_valid.
- busy  out  1  high whenever the state is not IDLE.
- irq  out  1  int_n synchronised and inverted.
- data_in  in  DATA_W  bus data from pins.
- data_out  out  DATA_W  bus data to pins.
- data_oe  out  1  drive enable for the data buffer.
- addr  out  ADDR_W  bus address.
- cs_n, rd_n, we_n  out  1  bus strobes, active low.
- rw_n  out  1  external flip-flop direction: 1 = read, 0 = write.
- int_n  in  1  W5300 interrupt, active low, asynchronous.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0 during rst, then 1 in IDLE. cs_n=rd_n=we_n=1, rw_n=1, data_oe=0, addr=0, data_out=0, rsp_valid=0, rsp_rdata=0, rsp_last=0, wdata_next=0, busy=0, irq=0.
- Reset asserted mid-access aborts the access immediately. The strobes return to reset values asynchronously and no rsp_valid is issued.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. A single counter reloads on each state entry.
- IDLE: req_ready=1. On accept, latch write, addr, wdata and len, set remaining=len, and go to SETUP.
- SETUP (T_SETUP cycles):
  - cs_n=0, addr driven.
  - rw_n=~write.
  - data_oe=write, with data_out driven for writes.
- STROBE (T_STROBE cycles): rd_n=0 for reads, we_n=0 for writes. For reads, data_in is captured into rsp_rdata on the clock edge that ends the last STROBE cycle.
- HOLD (T_HOLD cycles):
  - Strobes return high; cs_n, addr, data_oe and data_out stay unchanged.
  - rsp_valid=1 in the first HOLD cycle; rsp_last=1 if remaining==0.
  - For a write with remaining>0, wdata_next=1 in the same cycle. req_wdata is sampled on the following edge.
- RECOVER (T_RECOVER cycles): cs_n=1, data_oe=0, rw_n=1.
  - If remaining>0: decrement remaining and go to SETUP with the same addr.
  - If remaining==0: go to IDLE.
- Default single-read timeline, with acceptance at edge 0:
  - SETUP: cycle 1.
  - STROBE: cycles 2–5.
  - HOLD with rsp_valid: cycle 6.
  - RECOVER: cycles 7–8.
  - req_ready=1 again: cycle 9.
- Burst word period = T_SETUP+T_STROBE+T_HOLD+T_RECOVER = 8 cycles by default.
- req_len = all-ones gives 2^LEN_W accesses. The counter must not wrap early.
- data_oe is never high while rd_n=0.
- rw_n changes only while cs_n=1 or on SETUP entry, never during STROBE.
- irq uses a 2-flop synchroniser on int_n, then inversion: 2–3 cycles latency from the int_n edge.

Test Plan:
- Single read, defaults: req addr=0x200, len=0; data_in=0xA55A held stable → cs_n low cycles 1–6, rd_n low cycles 2–5, rsp_valid at cycle 6 with rsp_rdata=0xA55A and rsp_last=1, req_ready high at cycle 9.
- Single write addr=0x004, wdata=0x1234 → data_oe=1 and rw_n=0 in cycles 1–6, we_n low cycles 2–5, data_out=0x1234 throughout, rd_n never low.
- Read burst addr=0x22E, len=3, data_in stepping 0x0001..0x0004 per word → four rsp_valid pulses 8 cycles apart carrying 1, 2, 3, 4; rsp_last only on the fourth; cs_n high 2 cycles between words; addr constant.
- Write burst len=1 with wdata_next → second word sampled on the edge after the wdata_next pulse appears on data_out in the second SETUP; exactly two we_n pulses.
- Reset asserted during STROBE of a read → cs_n/rd_n high within the same cycle, no rsp_valid, req_ready=1 one cycle after rst deasserts.
- int_n driven low → irq=1 within 3 cycles; int_n high → irq=0 within 3 cycles. Sweep T_STROBE=1 and T_RECOVER=1 to confirm minimum timing.
